// File: rtl/mmio_ctrl_if.sv
// mmio_ctrl_if: groups the CPU dmem bus, the data-RAM port and the I/O outputs.
// Latency: none (signal bundle only).
// Backpressure: none; the dmem bus is strobe-based with a fixed 1-cycle read return.
//
// Modports:
//   slave  - the controller: receives CPU strobes and RAM read data and drives
//            load data, RAM controls, LEDs and the timer interrupt.
//   master - the CPU/RAM side (or a testbench standing in for both).
interface mmio_ctrl_if #(
   parameter int LED_WIDTH = 8,
   parameter int RAM_AW    = 10
);
   // CPU data-memory port
   logic                 dmem_wr;
   logic [31:0]          dmem_waddr;
   logic [31:0]          dmem_wdata;
   logic                 dmem_rd;
   logic [31:0]          dmem_raddr;
   logic [31:0]          dmem_rdata;

   // Data RAM port
   logic                 ram_we;
   logic [RAM_AW-1:0]    ram_waddr;
   logic [31:0]          ram_wdata;
   logic                 ram_re;
   logic [RAM_AW-1:0]    ram_raddr;
   logic [31:0]          ram_rdata;

   // Memory-mapped I/O outputs
   logic [LED_WIDTH-1:0] leds;
   logic                 timer_irq;

   modport slave (
      input  dmem_wr, dmem_waddr, dmem_wdata, dmem_rd, dmem_raddr, ram_rdata,
      output dmem_rdata, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
             leds, timer_irq
   );

   modport master (
      output dmem_wr, dmem_waddr, dmem_wdata, dmem_rd, dmem_raddr, ram_rdata,
      input  dmem_rdata, ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
             leds, timer_irq
   );
endinterface

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: dmem bus decoder routing to data RAM plus LED / compare-match timer registers.
// Latency: RAM controls combinational from the bus; load data returned exactly 1 cycle after dmem_rd.
// Backpressure: none; every strobe is accepted in its cycle, unmapped accesses are dropped / read 0.
//
// Ports:
//   clk  - system clock
//   rstn - synchronous active-low reset
//   bus  - mmio_ctrl_if.slave: dmem_* from the CPU, ram_* to/from the data RAM,
//          leds and timer_irq outputs
//
// I/O map (word offsets from IO_BASE): 0x00 LED, 0x04 CNT, 0x08 CMP,
// 0x0C CTRL {IRQ_EN, AUTO_RELOAD, EN}, 0x10 STAT {MATCH} (write 1 to clear).
module mmio_ctrl #(
   parameter int          LED_WIDTH = 8,
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
   parameter logic [31:0] IO_BASE   = 32'h0000_0100
) (
   input logic         clk,
   input logic         rstn,
   mmio_ctrl_if.slave  bus
);

   // Word addresses of the I/O registers (byte address bits [31:2]).
   localparam logic [29:0] A_LED  = IO_BASE[31:2];
   localparam logic [29:0] A_CNT  = IO_BASE[31:2] + 30'd1;
   localparam logic [29:0] A_CMP  = IO_BASE[31:2] + 30'd2;
   localparam logic [29:0] A_CTRL = IO_BASE[31:2] + 30'd3;
   localparam logic [29:0] A_STAT = IO_BASE[31:2] + 30'd4;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic w_waddr_ram;
   logic w_raddr_ram;
   logic w_wr_io;
   logic w_wr_led;
   logic w_wr_cnt;
   logic w_wr_cmp;
   logic w_wr_ctrl;
   logic w_wr_stat;
   logic w_unused_addr_lsbs;

   assign w_waddr_ram = (bus.dmem_waddr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
   assign w_raddr_ram = (bus.dmem_raddr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);

   // The RAM window takes precedence, so an I/O decode never fires on a RAM hit.
   assign w_wr_io   = bus.dmem_wr & ~w_waddr_ram;
   assign w_wr_led  = w_wr_io & (bus.dmem_waddr[31:2] == A_LED);
   assign w_wr_cnt  = w_wr_io & (bus.dmem_waddr[31:2] == A_CNT);
   assign w_wr_cmp  = w_wr_io & (bus.dmem_waddr[31:2] == A_CMP);
   assign w_wr_ctrl = w_wr_io & (bus.dmem_waddr[31:2] == A_CTRL);
   assign w_wr_stat = w_wr_io & (bus.dmem_waddr[31:2] == A_STAT);

   // Word-only bus: byte-lane bits carry no meaning.
   assign w_unused_addr_lsbs = ^{bus.dmem_waddr[1:0], bus.dmem_raddr[1:0]};

   // ------------------------------------------------------------------
   // RAM path: straight through from the dmem bus
   // ------------------------------------------------------------------
   assign bus.ram_we    = bus.dmem_wr & w_waddr_ram;
   assign bus.ram_waddr = bus.dmem_waddr[RAM_AW+1:2];
   assign bus.ram_wdata = bus.dmem_wdata;
   assign bus.ram_re    = bus.dmem_rd & w_raddr_ram;
   assign bus.ram_raddr = bus.dmem_raddr[RAM_AW+1:2];

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   logic [LED_WIDTH-1:0] r_leds;
   logic [31:0]          r_cnt;
   logic [31:0]          r_cmp;
   logic                 r_en;
   logic                 r_auto;
   logic                 r_irq_en;
   logic                 r_match;
   logic                 r_irq;
   logic                 r_sel_ram;
   logic [31:0]          r_io_q;

   // ------------------------------------------------------------------
   // I/O read mux (uses current register values, so a same-cycle write
   // to the register being read is not visible until the next read)
   // ------------------------------------------------------------------
   logic [31:0] w_io_rdata;

   always_comb begin
      w_io_rdata = '0;
      case (bus.dmem_raddr[31:2])
         A_LED:   w_io_rdata = 32'(r_leds);
         A_CNT:   w_io_rdata = r_cnt;
         A_CMP:   w_io_rdata = r_cmp;
         A_CTRL:  w_io_rdata = {29'd0, r_irq_en, r_auto, r_en};
         A_STAT:  w_io_rdata = {31'd0, r_match};
         default: w_io_rdata = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Read return: the select flag picks RAM data or the captured I/O value.
   // Both hold between loads so dmem_rdata is stable when idle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_sel_ram <= 1'b0;
         r_io_q    <= '0;
      end else if (bus.dmem_rd) begin
         r_sel_ram <= w_raddr_ram;
         if (!w_raddr_ram) begin
            r_io_q <= w_io_rdata;
         end
      end
   end

   assign bus.dmem_rdata = r_sel_ram ? bus.ram_rdata : r_io_q;

   // ------------------------------------------------------------------
   // LED register, timer and interrupt
   // ------------------------------------------------------------------
   // Match is evaluated on the pre-write CNT/CMP values of this cycle.
   logic w_match_now;
   assign w_match_now = r_en & (r_cnt == r_cmp);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_leds   <= '0;
         r_cnt    <= '0;
         r_cmp    <= '0;
         r_en     <= 1'b0;
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
         r_match  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_led) begin
            r_leds <= bus.dmem_wdata[LED_WIDTH-1:0];
         end
         if (w_wr_cmp) begin
            r_cmp <= bus.dmem_wdata;
         end
         if (w_wr_ctrl) begin
            r_en     <= bus.dmem_wdata[0];
            r_auto   <= bus.dmem_wdata[1];
            r_irq_en <= bus.dmem_wdata[2];
         end

         // A CPU write to CNT overrides both the increment and the reload.
         if (w_wr_cnt) begin
            r_cnt <= bus.dmem_wdata;
         end else if (r_en) begin
            r_cnt <= (w_match_now && r_auto) ? 32'd0 : r_cnt + 32'd1;
         end

         // A fresh match wins over a simultaneous write-1-to-clear.
         if (w_match_now) begin
            r_match <= 1'b1;
         end else if (w_wr_stat && bus.dmem_wdata[0]) begin
            r_match <= 1'b0;
         end

         r_irq <= r_match & r_irq_en;
      end
   end

   assign bus.leds      = r_leds;
   assign bus.timer_irq = r_irq;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed bench for mmio_ctrl with a load-data scoreboard.
// Latency: loads are expected on dmem_rdata one cycle after dmem_rd.
// Backpressure: none; stimulus drives one strobe per cycle.
module tb_mmio_ctrl;

   localparam logic [31:0] RAM_BASE = 32'h0000_1000;
   localparam logic [31:0] IO_BASE  = 32'h0000_0100;
   localparam logic [31:0] A_LED    = IO_BASE + 32'h00;
   localparam logic [31:0] A_CNT    = IO_BASE + 32'h04;
   localparam logic [31:0] A_CMP    = IO_BASE + 32'h08;
   localparam logic [31:0] A_CTRL   = IO_BASE + 32'h0C;
   localparam logic [31:0] A_STAT   = IO_BASE + 32'h10;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   int total = 0;
   int bad   = 0;

   mmio_ctrl_if #(.LED_WIDTH(8), .RAM_AW(10)) bus ();

   mmio_ctrl #(
      .LED_WIDTH (8),
      .RAM_AW    (10),
      .RAM_BASE  (RAM_BASE),
      .IO_BASE   (IO_BASE)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Behavioural data RAM with 1-cycle read latency, holding its output when idle.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   logic [31:0] exp_q [$];
   string       nm_q  [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   logic rd_pend = 1'b0;
   always @(posedge clk) rd_pend <= bus.dmem_rd;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_load: got %08h expected no load at %0t", bus.dmem_rdata, $time);
         end else begin
            chk(nm_q.pop_front(), bus.dmem_rdata, exp_q.pop_front());
         end
      end
   end

   // ------------------------------------------------------------------
   // Bus tasks: called just after a posedge, return just after the next one
   // ------------------------------------------------------------------
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.dmem_wr    = 1'b1;
      bus.dmem_waddr = a;
      bus.dmem_wdata = d;
      @(posedge clk); #1;
      bus.dmem_wr    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      bus.dmem_rd    = 1'b1;
      bus.dmem_raddr = a;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk); #1;
      bus.dmem_rd    = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.dmem_wr    = 1'b0;
      bus.dmem_waddr = '0;
      bus.dmem_wdata = '0;
      bus.dmem_rd    = 1'b0;
      bus.dmem_raddr = '0;

      // Reset state
      tick(3);
      chk("reset_leds", 32'(bus.leds), 32'h0);
      chk("reset_irq", 32'(bus.timer_irq), 32'h0);
      chk("reset_rdata", bus.dmem_rdata, 32'h0);
      rstn = 1'b1;
      rd(A_CNT,  32'h0, "reset_cnt");
      rd(A_CMP,  32'h0, "reset_cmp");
      rd(A_CTRL, 32'h0, "reset_ctrl");
      rd(A_STAT, 32'h0, "reset_stat");

      // LED register: truncation on write, zero-extension on read
      wr(A_LED, 32'h0000_01A5);
      chk("led_write", 32'(bus.leds), 32'h0000_00A5);
      rd(A_LED, 32'h0000_00A5, "led_read");

      // RAM write/read through the model RAM
      bus.dmem_wr = 1'b1; bus.dmem_waddr = RAM_BASE + 32'h10; bus.dmem_wdata = 32'hDEAD_BEEF;
      #1;
      chk("ram_we", 32'(bus.ram_we), 32'h1);
      chk("ram_waddr", 32'(bus.ram_waddr), 32'h4);
      chk("ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      bus.dmem_wr = 1'b0;
      bus.dmem_rd = 1'b1; bus.dmem_raddr = RAM_BASE + 32'h10;
      exp_q.push_back(32'hDEAD_BEEF); nm_q.push_back("ram_read");
      #1;
      chk("ram_re", 32'(bus.ram_re), 32'h1);
      chk("ram_raddr", 32'(bus.ram_raddr), 32'h4);
      @(posedge clk); #1;
      bus.dmem_rd = 1'b0;
      tick(2);
      chk("ram_rdata_hold", bus.dmem_rdata, 32'hDEAD_BEEF);

      // Read and write LED in the same cycle: read sees the old value
      bus.dmem_wr = 1'b1; bus.dmem_waddr = A_LED; bus.dmem_wdata = 32'h0000_003C;
      bus.dmem_rd = 1'b1; bus.dmem_raddr = A_LED;
      exp_q.push_back(32'h0000_00A5); nm_q.push_back("led_rd_during_wr");
      @(posedge clk); #1;
      bus.dmem_wr = 1'b0; bus.dmem_rd = 1'b0;
      rd(A_LED, 32'h0000_003C, "led_after_wr");

      // Auto-reload timer, CMP=5: count 0..5 then back to 0, period 6
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'd3);
      for (int i = 0; i < 9; i++) rd(A_CNT, 32'(i % 6), "cnt_autoreload");
      rd(A_STAT, 32'h1, "stat_match_set");
      wr(A_CTRL, 32'd0);                       // last enabled cycle takes CNT 4 -> 5
      rd(A_CNT, 32'd5, "cnt_frozen");
      wr(A_STAT, 32'h1);                       // CNT==CMP but EN=0: clear sticks
      rd(A_STAT, 32'h0, "stat_cleared_disabled");
      rd(A_CNT, 32'd5, "cnt_still_frozen");
      rd(A_CMP, 32'd5, "cmp_read");

      // Interrupt: CMP=3, EN|IRQ_EN (upper CTRL bits written as ones)
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'hFFFF_FFFD);
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("irq_rise", 32'(bus.timer_irq), (k == 5) ? 32'h1 : 32'h0);
      end
      wr(A_STAT, 32'h1);
      chk("irq_hold_after_clear", 32'(bus.timer_irq), 32'h1);
      tick(1);
      chk("irq_fall", 32'(bus.timer_irq), 32'h0);
      rd(A_CNT, 32'd7, "cnt_past_cmp");
      rd(A_CTRL, 32'd5, "ctrl_readback");
      rd(A_STAT, 32'h0, "stat_after_w1c");

      // CNT write beats the increment
      wr(A_CNT, 32'h0000_0100);
      rd(A_CNT, 32'h0000_0100, "cnt_write_priority");

      // Match beats a simultaneous W1C
      wr(A_CTRL, 32'd0);
      wr(A_CNT, 32'd7);
      wr(A_CMP, 32'd7);
      wr(A_STAT, 32'h1);
      wr(A_CTRL, 32'd1);
      wr(A_STAT, 32'h1);
      rd(A_STAT, 32'h1, "match_beats_w1c");
      rd(A_CNT, 32'd9, "cnt_after_match");
      chk("irq_masked", 32'(bus.timer_irq), 32'h0);

      // Unmapped addresses
      wr(IO_BASE + 32'h20, 32'hFFFF_FFFF);
      rd(IO_BASE + 32'h20, 32'h0, "unmapped_io_read");
      rd(IO_BASE + 32'h14, 32'h0, "unmapped_io_gap");
      bus.dmem_wr = 1'b1; bus.dmem_waddr = 32'h0000_0800; bus.dmem_wdata = 32'h1234_5678;
      #1;
      chk("unmapped_no_ram_we", 32'(bus.ram_we), 32'h0);
      @(posedge clk); #1;
      bus.dmem_wr = 1'b0;
      rd(32'h0000_0800, 32'h0, "unmapped_low_read");
      chk("leds_unchanged", 32'(bus.leds), 32'h0000_003C);

      // Reset mid-operation with LEDs lit, timer running, irq high and a RAM load pending
      wr(A_CTRL, 32'd0);
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd1);
      wr(A_STAT, 32'h1);
      wr(A_CTRL, 32'd5);
      wr(A_LED, 32'h0000_00FF);
      tick(3);
      chk("pre_reset_irq", 32'(bus.timer_irq), 32'h1);
      chk("pre_reset_leds", 32'(bus.leds), 32'h0000_00FF);
      rd(RAM_BASE + 32'h10, 32'hDEAD_BEEF, "pre_reset_ram_read");
      rstn = 1'b0;
      rd(RAM_BASE + 32'h10, 32'h0, "load_lost_in_reset");
      chk("midreset_leds", 32'(bus.leds), 32'h0);
      chk("midreset_irq", 32'(bus.timer_irq), 32'h0);
      rstn = 1'b1;
      rd(A_CNT,  32'h0, "midreset_cnt");
      rd(A_CMP,  32'h0, "midreset_cmp");
      rd(A_CTRL, 32'h0, "midreset_ctrl");
      rd(A_STAT, 32'h0, "midreset_stat");
      rd(A_LED,  32'h0, "midreset_led");

      // Drain: every expected load must have been seen
      tick(3);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
Data-memory bus controller between the tiny_riscv1 dmem port and the system resources. It decodes CPU load/store addresses and routes RAM-region accesses to a synchronous single-port-per-direction data RAM. It also implements the memory-mapped I/O register file: the LED register plus a compare-match timer with interrupt. It replaces the ad-hoc LED decode and constant-zero read data in top.

Parameters:
LED_WIDTH, 8, width of leds output and LED register
RAM_AW, 10, data RAM word-address width (RAM depth 2^RAM_AW words)
RAM_BASE, 32'h0000_1000, byte base address of RAM region (aligned to 4*2^RAM_AW)
IO_BASE, 32'h0000_0100, byte base address of I/O register block

Ports:
clk  input  1  system clock
rstn  input  1  reset; synchronous, active-low
dmem_wr  input  1  CPU store strobe, one cycle per store
dmem_waddr  input  32  CPU store byte address
dmem_wdata  input  32  CPU store data
dmem_rd  input  1  CPU load strobe, one cycle per load
dmem_raddr  input  32  CPU load byte address
dmem_rdata  output  32  load data, valid cycle after dmem_rd
ram_we  output  1  RAM write enable
ram_waddr  output  RAM_AW  RAM word write address
ram_wdata  output  32  RAM write data
ram_re  output  1  RAM read enable
ram_raddr  output  RAM_AW  RAM word read address
ram_rdata  input  32  RAM read data, 1-cycle synchronous latency
leds  output  LED_WIDTH  LED register value
timer_irq  output  1  timer interrupt, level

Behaviour:
- Clock clk only; reset synchronous active-low on rstn, all state sampled at posedge clk.
- Reset values: dmem_rdata 0, leds 0, timer_irq 0, all timer registers 0, read-select flag = I/O.
- Address decode, addr[1:0] ignored (word access only):
  - RAM hit: addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]; word addr = addr[RAM_AW+1:2].
  - IO_BASE+0x00 LED: RW, bits [LED_WIDTH-1:0]; reads zero-extended.
  - IO_BASE+0x04 CNT: RW, 32-bit timer count.
  - IO_BASE+0x08 CMP: RW, 32-bit compare value.
  - IO_BASE+0x0C CTRL: RW, bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - IO_BASE+0x10 STAT: bit0 MATCH; read; write 1 clears, write 0 no effect.
  - Any other address: writes dropped, reads return 0.
- RAM path: ram_we = dmem_wr & RAM hit (combinational), ram_waddr/ram_wdata direct from dmem bus. Same for ram_re/ram_raddr from read bus.
- Read latency exactly 1 cycle for every region:
  - On dmem_rd, register sel_ram.
  - On dmem_rd to a non-RAM address, register the I/O read value into io_q.
  - dmem_rdata = sel_ram ? ram_rdata : io_q.
  - With no dmem_rd, sel_ram and io_q hold, so dmem_rdata holds the last value (RAM data held only if RAM holds its output).
- Read and write to same I/O register in same cycle: read returns pre-write value.
- Timer, each cycle with EN=1:
  - If CNT == CMP: set MATCH; CNT <= AUTO_RELOAD ? 0 : CNT+1.
  - Else CNT <= CNT+1, wrapping 32'hFFFF_FFFF -> 0.
  - EN=0: CNT frozen, no match detection.
- timer_irq = MATCH & IRQ_EN, registered: asserts the cycle after MATCH/IRQ_EN become 1, deasserts the cycle after either clears.
- Priority and simultaneous events:
  - CPU write to CNT beats the increment or reload in the same cycle.
  - New match beats a W1C to STAT in the same cycle (MATCH stays 1).
  - Match compares current CNT against CMP before any same-cycle CMP write.
- Reset asserted mid-operation: next edge forces all reset values; a pending read's data is lost (dmem_rdata 0).

Test Plan:
- Reset, then write LED (IO_BASE) 32'h0000_01A5 -> leds = 8'hA5 next cycle; read LED -> dmem_rdata 32'h0000_00A5 one cycle after dmem_rd.
- Write RAM_BASE+0x10 = 32'hDEADBEEF -> ram_we=1, ram_waddr=4. Read same address with model RAM -> dmem_rdata 32'hDEADBEEF at rd+1.
- CMP=5, CTRL=3 (EN|AUTO_RELOAD) -> CNT counts 0..5, MATCH set at 5, CNT returns to 0 and cycles with period 6; STAT read -> 1.
- CTRL=5 (EN|IRQ_EN), CMP=3 -> timer_irq rises the cycle after the match. Write STAT=1 -> irq low the cycle after the clear, CNT keeps counting past 3.
- CNT write 32'h0000_0100 in the same cycle as an increment -> CNT=0x100 (not 0x101); W1C coinciding with a match -> MATCH stays 1.
- Access IO_BASE+0x20 and address 0x0000_0800 -> writes ignored, reads 0. Assert rstn=0 with leds=0xFF and timer running -> all registers and outputs 0 after the next clk edge.
